// File: rtl/t07_spi_ext_regfile.sv
// External register bank fed by the octal SPI receiver.
// Address/data strobe pairs are written into a NUM_REGS x DATA_W bank that the
// CPU reads with one cycle of latency. Per-register "new" flags, a frame-done
// pulse and a saturating protocol-error counter report fresh data and bad framing.
`timescale 1ns/1ps

module t07_spi_ext_regfile #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ERR_W    = 8
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                spi_cs_n,
    input  logic                spi_addr_valid,
    input  logic [ADDR_W-1:0]   spi_addr,
    input  logic                spi_data_valid,
    input  logic [DATA_W-1:0]   spi_data,
    input  logic                cpu_rd_en,
    input  logic [ADDR_W-1:0]   cpu_rd_addr,
    output logic [DATA_W-1:0]   cpu_rd_data,
    output logic                cpu_rd_valid,
    output logic                cpu_rd_new,
    output logic [NUM_REGS-1:0] new_mask,
    output logic                frame_done,
    output logic [ERR_W-1:0]    err_count,
    input  logic                clr_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ADDR,
        WAIT_DATA
    } state_t;

    localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(NUM_REGS - 1);

    state_t              state;
    logic [ADDR_W-1:0]   pend_addr;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic                commit;
    logic                wr_en;
    logic                err_event;
    logic                pend_in_range;
    logic                rd_in_range;
    logic [NUM_REGS-1:0] wr_set;
    logic [NUM_REGS-1:0] rd_clr;

    assign pend_in_range = {1'b0, pend_addr} < NUM_REGS_EXT;
    assign rd_in_range   = {1'b0, cpu_rd_addr} < NUM_REGS_EXT;

    // Decode the strobes seen in the current state into write and error events.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        commit    = 1'b0;
        err_event = 1'b0;
        wr_set    = '0;
        rd_clr    = '0;
        case (state)
            WAIT_ADDR: begin
                // Data without a preceding address is an orphan, even if an
                // address arrives in the same cycle.
                if (!spi_cs_n) err_event = spi_data_valid;
            end
            WAIT_DATA: begin
                if (spi_cs_n) begin
                    // Chip select dropped with a write still outstanding.
                    err_event = 1'b1;
                end else begin
                    commit    = spi_data_valid;
                    // A second address before the data replaces the pending one.
                    err_event = spi_addr_valid;
                end
            end
            default: ;
        endcase
        wr_en = commit && pend_in_range;
        if (commit && !pend_in_range) err_event = 1'b1;
        if (wr_en) wr_set[pend_addr] = 1'b1;
        if (cpu_rd_en && rd_in_range) rd_clr[cpu_rd_addr] = 1'b1;
    end

    // Transfer framing FSM: tracks chip select, pending address and frame end.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: state is updated with non-blocking assignments so every block
        // clocked on this edge sees the pre-edge values regardless of order.
        if (!nrst) begin
            state      <= IDLE;
            pend_addr  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!spi_cs_n) state <= WAIT_ADDR;
                end
                WAIT_ADDR: begin
                    if (spi_cs_n) begin
                        state <= IDLE;
                    end else if (spi_addr_valid) begin
                        pend_addr <= spi_addr;
                        state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (spi_cs_n) begin
                        state <= IDLE;
                    end else begin
                        if (commit && pend_addr == LAST_ADDR) frame_done <= 1'b1;
                        if (spi_addr_valid) begin
                            pend_addr <= spi_addr;
                        end else if (spi_data_valid) begin
                            state <= WAIT_ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register bank write port, cleared on reset.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: the bank is built from flops with an async clear because firmware
        // relies on every register reading 0 after reset; a RAM macro could not.
        if (!nrst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[pend_addr] <= spi_data;
        end
    end

    // New flags: a read clears its flag, a write sets it; the write wins on collision.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            new_mask <= '0;
        end else begin
            new_mask <= (new_mask & ~rd_clr) | wr_set;
        end
    end

    // CPU read port: data and new flag as they were in the request cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cpu_rd_data  <= '0;
            cpu_rd_valid <= 1'b0;
            cpu_rd_new   <= 1'b0;
        end else begin
            cpu_rd_valid <= cpu_rd_en;
            if (cpu_rd_en) begin
                cpu_rd_data <= rd_in_range ? regs[cpu_rd_addr] : '0;
                cpu_rd_new  <= rd_in_range && new_mask[cpu_rd_addr];
            end
        end
    end

    // Saturating protocol-error counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= '0;
        end else if (err_event && err_count != '1) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_t07_spi_ext_regfile.sv
// Self-checking bench for t07_spi_ext_regfile: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// transaction-level model of the register file.
`timescale 1ns/1ps

module tb_t07_spi_ext_regfile;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_addr_valid = 1'b0;
    logic [4:0]  spi_addr = '0;
    logic        spi_data_valid = 1'b0;
    logic [31:0] spi_data = '0;
    logic        cpu_rd_en = 1'b0;
    logic [4:0]  cpu_rd_addr = '0;
    logic [31:0] cpu_rd_data;
    logic        cpu_rd_valid;
    logic        cpu_rd_new;
    logic [31:0] new_mask;
    logic        frame_done;
    logic [7:0]  err_count;
    logic        clr_err = 1'b0;

    int total = 0;
    int bad   = 0;
    int fd_count = 0;

    t07_spi_ext_regfile dut (
        .clk            (clk),
        .nrst           (nrst),
        .spi_cs_n       (spi_cs_n),
        .spi_addr_valid (spi_addr_valid),
        .spi_addr       (spi_addr),
        .spi_data_valid (spi_data_valid),
        .spi_data       (spi_data),
        .cpu_rd_en      (cpu_rd_en),
        .cpu_rd_addr    (cpu_rd_addr),
        .cpu_rd_data    (cpu_rd_data),
        .cpu_rd_valid   (cpu_rd_valid),
        .cpu_rd_new     (cpu_rd_new),
        .new_mask       (new_mask),
        .frame_done     (frame_done),
        .err_count      (err_count),
        .clr_err        (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_new = '0;
    int          m_err = 0;
    bit          m_active = 0;   // chip select seen low, transfer open
    bit          m_waiting = 0;  // an address was received, its data has not
    logic [4:0]  m_pend = '0;
    bit          exp_rd_valid = 0;
    logic [31:0] exp_rd_data = '0;
    bit          exp_rd_new = 0;
    bit          exp_fd = 0;
    bit          ev;
    logic [31:0] nm;

    initial for (int i = 0; i < 32; i++) m_regs[i] = '0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_new = '0; m_err = 0; m_active = 0; m_waiting = 0; m_pend = '0;
            exp_rd_valid = 0; exp_rd_data = '0; exp_rd_new = 0; exp_fd = 0;
        end else begin
            ev = 0;
            nm = m_new;
            exp_fd = 0;
            exp_rd_valid = cpu_rd_en;
            if (cpu_rd_en) begin
                exp_rd_data = m_regs[cpu_rd_addr];
                exp_rd_new  = m_new[cpu_rd_addr];
                nm[cpu_rd_addr] = 1'b0;
            end
            if (!m_active) begin
                if (!spi_cs_n) m_active = 1;
            end else if (spi_cs_n) begin
                ev = m_waiting;
                m_active = 0;
                m_waiting = 0;
            end else begin
                if (spi_data_valid) begin
                    if (m_waiting) begin
                        m_regs[m_pend] = spi_data;
                        nm[m_pend] = 1'b1;
                        if (m_pend == 5'd31) exp_fd = 1;
                    end else begin
                        ev = 1;
                    end
                end
                if (spi_addr_valid) begin
                    if (m_waiting) ev = 1;
                    m_pend = spi_addr;
                    m_waiting = 1;
                end else if (spi_data_valid) begin
                    m_waiting = 0;
                end
            end
            m_new = nm;
            if (clr_err) m_err = 0;
            else if (ev && m_err < 255) m_err++;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (nrst) begin
            check("frame_done", frame_done, exp_fd);
            check("err_count", err_count, m_err);
            check("new_mask", new_mask, m_new);
            check("rd_valid", cpu_rd_valid, exp_rd_valid);
            if (exp_rd_valid) begin
                check("rd_data", cpu_rd_data, exp_rd_data);
                check("rd_new", cpu_rd_new, exp_rd_new);
            end
        end
    end

    // Counts frame_done pulses for the directed frame check.
    always @(negedge clk) if (nrst && frame_done) fd_count++;

    // ---------------- stimulus ----------------
    task automatic drive(input bit cs, input bit av, input logic [4:0] a,
                         input bit dv, input logic [31:0] d,
                         input bit re, input logic [4:0] ra, input bit ce);
        @(negedge clk);
        spi_cs_n = cs; spi_addr_valid = av; spi_addr = a;
        spi_data_valid = dv; spi_data = d;
        cpu_rd_en = re; cpu_rd_addr = ra; clr_err = ce;
    endtask

    task automatic idle(input bit cs);
        drive(cs, 0, 5'd0, 0, 32'd0, 0, 5'd0, 0);
    endtask

    task automatic rd(input bit cs, input logic [4:0] ra);
        drive(cs, 0, 5'd0, 0, 32'd0, 1, ra, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset rd_data", cpu_rd_data, 0);
        check("reset rd_valid", cpu_rd_valid, 0);
        check("reset rd_new", cpu_rd_new, 0);
        check("reset new_mask", new_mask, 0);
        check("reset frame_done", frame_done, 0);
        check("reset err_count", err_count, 0);
        nrst = 1'b1;

        // One full frame, data 3 cycles after each address.
        idle(0);
        for (int k = 0; k < 32; k++) begin
            drive(0, 1, 5'(k), 0, 32'd0, 0, 5'd0, 0);
            idle(0);
            idle(0);
            drive(0, 0, 5'd0, 1, 32'hA500_0000 + 32'(k), 0, 5'd0, 0);
        end
        idle(0);
        idle(0);
        check("frame new_mask", new_mask, 32'hFFFF_FFFF);
        check("frame fd_count", fd_count, 1);
        check("frame err_count", err_count, 0);

        // Read register 7 twice: fresh then stale.
        rd(0, 5'd7);
        idle(0);
        check("rd7 data", cpu_rd_data, 32'hA500_0007);
        check("rd7 valid", cpu_rd_valid, 1);
        check("rd7 new", cpu_rd_new, 1);
        check("rd7 mask bit", new_mask[7], 0);
        rd(0, 5'd7);
        idle(0);
        check("rd7 again new", cpu_rd_new, 0);

        // Collision: write to 3 committed while 3 is being read.
        drive(0, 1, 5'd3, 0, 32'd0, 0, 5'd0, 0);
        drive(0, 0, 5'd0, 1, 32'h1234_5678, 1, 5'd3, 0);
        idle(0);
        check("coll old data", cpu_rd_data, 32'hA500_0003);
        check("coll mask bit", new_mask[3], 1);
        rd(0, 5'd3);
        idle(0);
        check("coll new data", cpu_rd_data, 32'h1234_5678);

        // Protocol errors: orphan data, address overwrite, cs drop in WAIT_DATA.
        drive(0, 0, 5'd0, 1, 32'hDEAD_0001, 0, 5'd0, 0);
        drive(0, 1, 5'd4, 0, 32'd0, 0, 5'd0, 0);
        drive(0, 1, 5'd5, 0, 32'd0, 0, 5'd0, 0);
        idle(1);
        idle(1);
        check("proto err_count", err_count, 3);
        rd(1, 5'd4);
        idle(1);
        check("proto reg4", cpu_rd_data, 32'hA500_0004);
        rd(1, 5'd5);
        idle(1);
        check("proto reg5", cpu_rd_data, 32'hA500_0005);

        // Saturation then clear colliding with an error.
        idle(0);
        for (int i = 0; i < 300; i++) drive(0, 0, 5'd0, 1, 32'(i), 0, 5'd0, 0);
        idle(0);
        check("sat err_count", err_count, 255);
        drive(0, 0, 5'd0, 1, 32'd0, 0, 5'd0, 1);
        idle(0);
        check("clr err_count", err_count, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) < 4,
                  $urandom_range(99) < 35, 5'($urandom_range(31)),
                  $urandom_range(99) < 35, $urandom,
                  $urandom_range(99) < 40, 5'($urandom_range(31)),
                  $urandom_range(99) < 2);
        end

        // Async reset in the middle of WAIT_DATA.
        idle(1);
        idle(0);
        drive(0, 1, 5'd9, 0, 32'd0, 0, 5'd0, 0);
        idle(0);
        #2 nrst = 1'b0;
        #1;
        check("arst rd_data", cpu_rd_data, 0);
        check("arst rd_valid", cpu_rd_valid, 0);
        check("arst rd_new", cpu_rd_new, 0);
        check("arst new_mask", new_mask, 0);
        check("arst frame_done", frame_done, 0);
        check("arst err_count", err_count, 0);
        @(negedge clk);
        nrst = 1'b1;
        drive(0, 0, 5'd0, 1, 32'hCAFE_F00D, 0, 5'd0, 0);
        idle(0);
        check("arst orphan err", err_count, 1);
        check("arst orphan mask", new_mask, 0);
        rd(0, 5'd9);
        idle(0);
        check("arst reg9", cpu_rd_data, 0);
        idle(1);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
